// File: rtl/cvt_result_queue.sv
// Result FIFO behind the cvtsw converter. Buffers each float with its inexact
// bit and tracks a sticky inexact flag plus a saturating inexact-event count.
module cvt_result_queue #(
  parameter int NEXP  = 8,
  parameter int NSIG  = 23,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NEXP+NSIG:0]         in_s,
  input  logic                       in_inexact,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NEXP+NSIG:0]         out_s,
  output logic                       out_inexact,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       flag_inexact,
  output logic [CNTW-1:0]            inexact_cnt,
  input  logic                       flag_clr
);
  localparam int W  = NEXP + NSIG + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);
  localparam logic [CNTW-1:0] CMAX = '1;

  logic [W-1:0]  mem_s [DEPTH];
  logic          mem_x [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, push_x;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push_x    = push & in_inexact;

  assign out_s       = out_valid ? mem_s[rd_ptr] : '0;
  assign out_inexact = out_valid & mem_x[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_s[wr_ptr] <= in_s;
      mem_x[wr_ptr] <= in_inexact;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An inexact push in the same cycle as a clear takes priority over it.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_inexact <= 1'b0;
      inexact_cnt  <= '0;
    end else begin
      if (push_x)        flag_inexact <= 1'b1;
      else if (flag_clr) flag_inexact <= 1'b0;

      if (flag_clr)
        inexact_cnt <= push_x ? CNTW'(1) : '0;
      else if (push_x && inexact_cnt != CMAX)
        inexact_cnt <= inexact_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cvt_result_queue.sv
// Randomized and directed bench for cvt_result_queue against a queue-based model.
module tb_cvt_result_queue;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst, in_valid, in_inexact, out_ready, flag_clr;
  logic [31:0] in_s;
  logic        in_ready, out_valid, out_inexact, flag_inexact;
  logic [31:0] out_s;
  logic [2:0]  count;
  logic [15:0] inexact_cnt;
  logic        in_ready2, out_valid2, out_inexact2, flag_inexact2;
  logic [31:0] out_s2;
  logic [2:0]  count2;
  logic [1:0]  inexact_cnt2;

  cvt_result_queue #(.DEPTH(DEPTH), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_inexact(in_inexact), .out_valid(out_valid),
    .out_ready(out_ready), .out_s(out_s), .out_inexact(out_inexact),
    .count(count), .flag_inexact(flag_inexact), .inexact_cnt(inexact_cnt),
    .flag_clr(flag_clr));

  // Narrow-counter build sharing the same stimulus, for saturation.
  cvt_result_queue #(.DEPTH(DEPTH), .CNTW(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_s(in_s), .in_inexact(in_inexact), .out_valid(out_valid2),
    .out_ready(out_ready), .out_s(out_s2), .out_inexact(out_inexact2),
    .count(count2), .flag_inexact(flag_inexact2), .inexact_cnt(inexact_cnt2),
    .flag_clr(flag_clr));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] s; bit x; } ent_t;
  ent_t q[$];
  bit   m_flag;
  int   m_cnt, m_cnt2;
  int   errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count",     32'(count),        32'(q.size()));
    chk("out_valid", 32'(out_valid),    32'(q.size() != 0));
    chk("in_ready",  32'(in_ready),     32'(q.size() < DEPTH));
    chk("out_s",     out_s,             q.size() ? q[0].s : 32'h0);
    chk("out_inx",   32'(out_inexact),  q.size() ? 32'(q[0].x) : 32'h0);
    chk("flag",      32'(flag_inexact), 32'(m_flag));
    chk("cnt",       32'(inexact_cnt),  32'(m_cnt));
    chk("cnt_sat",   32'(inexact_cnt2), 32'(m_cnt2));
  endtask

  // One clock: drive inputs, predict from pre-edge state, update model, check.
  task automatic step(input bit r, input bit v, input logic [31:0] s,
                      input bit x, input bit ordy, input bit clr);
    bit do_push, do_pop;
    rst = r; in_valid = v; in_s = s; in_inexact = x; out_ready = ordy; flag_clr = clr;
    do_push = !r && v && (q.size() < DEPTH);
    do_pop  = !r && ordy && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete(); m_flag = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      ent_t e;
      e.s = s; e.x = x;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
      if (do_push && x) begin
        m_flag = 1;
        m_cnt  = clr ? 1 : (m_cnt  < 65535 ? m_cnt + 1  : 65535);
        m_cnt2 = clr ? 1 : (m_cnt2 < 3     ? m_cnt2 + 1 : 3);
      end else if (clr) begin
        m_flag = 0; m_cnt = 0; m_cnt2 = 0;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    m_flag = 0; m_cnt = 0; m_cnt2 = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic flow
    step(0, 1, 32'h3F800000, 0, 1, 0);
    chk("basic_first", out_s, 32'h3F800000);
    step(0, 1, 32'hBF800000, 0, 1, 0);
    chk("basic_second", out_s, 32'hBF800000);
    step(0, 0, 0, 0, 1, 0);
    chk("basic_empty", 32'(count), 32'd0);

    // Fill and stall, then drain
    for (int k = 0; k < 5; k++) step(0, 1, 32'h40000000 + k, 0, 0, 0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(0, 0, 0, 0, 1, 0);
    chk("ready_after_pop", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);

    // Inexact tracking
    step(0, 1, 32'h4B800000, 1, 1, 0);
    chk("inx_flag", 32'(flag_inexact), 32'd1);
    step(0, 1, 32'h4B800000, 0, 1, 0);
    chk("inx_cnt", 32'(inexact_cnt), 32'd1);
    step(0, 0, 0, 0, 1, 0);

    // Clear collision: bring count to 3 first
    for (int k = 0; k < 2; k++) step(0, 1, 32'h4B800000, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("pre_clr_cnt", 32'(inexact_cnt), 32'd3);
    step(0, 1, 32'h4B800000, 1, 1, 1);
    chk("clr_coll_cnt", 32'(inexact_cnt), 32'd1);
    step(0, 0, 0, 0, 1, 1);
    chk("clr_alone_flag", 32'(flag_inexact), 32'd0);

    // Saturation of the narrow counter
    for (int k = 0; k < 5; k++) step(0, 1, 32'h3F000000 + k, 1, 1, 0);
    chk("sat_cnt2", 32'(inexact_cnt2), 32'd3);
    step(0, 0, 0, 0, 1, 0);

    // Simultaneous push and pop at count=2
    step(0, 1, 32'h3F7FFFFE, 0, 0, 0);
    step(0, 1, 32'h3F7FFFFF, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 1, 32'h3F800000 + k, 0, 1, 0);
    chk("pp_count", 32'(count), 32'd2);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Reset mid-stream
    step(0, 1, 32'h11111111, 1, 0, 0);
    step(0, 1, 32'h22222222, 0, 0, 0);
    step(0, 1, 32'h33333333, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++)
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
